// File: rtl/nios_pio_pkg.sv
// Shared constants for the PIO capture block: Avalon register map, edge-type encodings
// and the per-bit edge detector.
package nios_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  // Wide enough for the largest supported stability count (65535).
  localparam int unsigned DEB_CNT_W = 16;

  function automatic logic edge_detect(input int unsigned etype, input logic cur,
                                       input logic prv);
    if (etype == EDGE_FALLING) begin
      return ~cur & prv;
    end else if (etype == EDGE_ANY) begin
      return cur ^ prv;
    end else begin
      return cur & ~prv;
    end
  endfunction

endpackage

// File: rtl/nios_pio_debounce.sv
// One input bit: synchronizer chain followed by an optional consecutive-cycle debounce filter.
module nios_pio_debounce
  import nios_pio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_in,
  input  logic i_blank,
  output logic o_stable
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    logic w_unused_blank;
    assign w_unused_blank = i_blank;
    assign o_stable       = w_sync;
  end else begin : g_debounce
    localparam logic [DEB_CNT_W-1:0] CntMax = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 r_stable;
    logic [DEB_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_stable <= 1'b0;
        r_cnt    <= '0;
      end else if (i_blank) begin
        r_stable <= w_sync;
        r_cnt    <= '0;
      end else if (w_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        r_stable <= w_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    // While blanking, present the synchronizer directly so prev tracks the settled input
    // and no spurious edge appears once capture is enabled.
    assign o_stable = i_blank ? w_sync : r_stable;
  end

endmodule

// File: rtl/nios_pio_capture.sv
// Avalon-MM PIO input port with synchronization, optional debounce, edge capture and a
// maskable level interrupt.
module nios_pio_capture
  import nios_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] BlankLen = 3'(SYNC_STAGES + 1);

  logic [2:0]       r_blank_cnt;
  logic             w_blank;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdata;
  logic [31:0]      r_readdata;
  logic             w_wr;
  logic [31:0]      w_unused_wdata;

  assign w_unused_wdata = writedata;

  // Capture stays blanked until the synchronizer has flushed out its reset contents.
  assign w_blank = (r_blank_cnt != BlankLen);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blank_cnt <= '0;
    end else if (w_blank) begin
      r_blank_cnt <= r_blank_cnt + 3'd1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_pio_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .i_in    (in_port[i]),
      .i_blank (w_blank),
      .o_stable(w_stable[i])
    );
  end

  always_comb begin
    w_edge = '0;
    if (!w_blank) begin
      for (int i = 0; i < WIDTH; i++) begin
        w_edge[i] = edge_detect(EDGE_TYPE, w_stable[i], r_prev[i]);
      end
    end
  end

  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev    <= '0;
      r_irqmask <= '0;
      r_edgecap <= '0;
    end else begin
      r_prev <= w_stable;
      if (w_wr && address == ADDR_IRQMASK) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
      // A new edge beats a simultaneous write-1-to-clear.
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (address)
      ADDR_DATA:    w_rdata[WIDTH-1:0] = w_stable;
      ADDR_RSVD:    w_rdata            = '0;
      ADDR_IRQMASK: w_rdata[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: w_rdata[WIDTH-1:0] = r_edgecap;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_nios_pio_capture.sv
// Directed bench: three configurations share one bus; a register-map vector table plus
// hand-written sequences for edge, debounce, blanking and reset corner cases.
module tb_nios_pio_capture;
  import nios_pio_pkg::*;

  localparam int unsigned SyncStages = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        cs_a = 1'b0, cs_b = 1'b0, cs_c = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_a = 4'b1010;
  logic [3:0]  in_b = 4'b0000;
  logic [31:0] in_c = '0;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nios_pio_capture #(
    .WIDTH(4), .SYNC_STAGES(SyncStages), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(EDGE_RISING)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a), .write_n(write_n),
    .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a)
  );

  nios_pio_capture #(
    .WIDTH(4), .SYNC_STAGES(SyncStages), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(EDGE_RISING)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b), .write_n(write_n),
    .writedata(writedata), .in_port(in_b), .readdata(rd_b), .irq(irq_b)
  );

  nios_pio_capture #(
    .WIDTH(32), .SYNC_STAGES(SyncStages), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_ANY)
  ) u_dut_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_c), .write_n(write_n),
    .writedata(writedata), .in_port(in_c), .readdata(rd_c), .irq(irq_c)
  );

  typedef struct {
    logic        cs;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input int dut, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs_a      = (dut == 0);
    cs_b      = (dut == 1);
    cs_c      = (dut == 2);
    tick(1);
    write_n = 1'b1;
    cs_a    = 1'b0;
    cs_b    = 1'b0;
    cs_c    = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit found;
    // cs, wr, addr, wdata, expected readdata (pre-write value on writes), expected irq
    vecs[0]  = '{1'b0, 1'b0, 2'd0, 32'h0,        32'hA, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'd1, 32'h0,        32'h0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'd2, 32'h0,        32'h0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'd3, 32'h0,        32'h0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 2'd2, 32'hFFFFFFFF, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 2'd2, 32'h0,        32'hF, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 2'd1, 32'hFFFFFFFF, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'd1, 32'h0,        32'h0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 2'd0, 32'h5,        32'hA, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 32'h0,        32'hA, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'd2, 32'h0,        32'hF, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 2'd2, 32'h0,        32'hF, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 2'd2, 32'hFFFFFFF6, 32'hF, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 2'd2, 32'h0,        32'h6, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 2'd3, 32'hFFFFFFFF, 32'h0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 2'd3, 32'h0,        32'h0, 1'b0};

    // Reset state
    tick(2);
    check("reset_rd_a", rd_a, 32'h0);
    check("reset_irq_a", irq_a, 1'b0);
    check("reset_rd_c", rd_c, 32'h0);
    reset_n = 1'b1;
    tick(12);

    // Register map, in_a = 1010 held since reset
    for (int i = 0; i < 16; i++) begin
      address   = vecs[i].addr;
      writedata = vecs[i].wdata;
      cs_a      = vecs[i].cs;
      write_n   = ~vecs[i].wr;
      tick(1);
      cs_a    = 1'b0;
      write_n = 1'b1;
      check($sformatf("vec%0d_rd", i), rd_a, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), irq_a, vecs[i].exp_irq);
    end

    // Rising edge on bit0 raises irq within SYNC_STAGES+2 cycles; W1C drops it next cycle
    bus_write(0, ADDR_IRQMASK, 32'h1);
    in_a  = 4'b1011;
    found = 1'b0;
    for (int i = 0; i < SyncStages + 2; i++) begin
      if (!found) begin
        tick(1);
        found = irq_a;
      end
    end
    check("rise_irq_in_time", irq_a, 1'b1);
    bus_read(ADDR_EDGECAP);
    check("rise_edgecap", rd_a, 32'h1);
    bus_write(0, ADDR_EDGECAP, 32'h1);
    check("w1c_irq_low", irq_a, 1'b0);
    bus_read(ADDR_EDGECAP);
    check("w1c_edgecap", rd_a, 32'h0);

    // Edge on bit2 coincides with a clear of bit2: the edge wins
    in_a = 4'b1111;
    tick(2);
    bus_write(0, ADDR_EDGECAP, 32'h4);
    bus_read(ADDR_EDGECAP);
    check("set_beats_clear", rd_a, 32'h4);

    // Falling edge ignored in rising mode; mask change takes effect next cycle
    in_a = 4'b1110;
    tick(5);
    bus_read(ADDR_EDGECAP);
    check("fall_ignored", rd_a, 32'h4);
    check("masked_irq", irq_a, 1'b0);
    bus_write(0, ADDR_IRQMASK, 32'h4);
    check("mask_irq", irq_a, 1'b1);

    // Asynchronous reset mid-cycle, then release with all inputs high
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_rd", rd_a, 32'h0);
    check("async_rst_irq", irq_a, 1'b0);
    in_a = 4'hF;
    in_b = 4'hF;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    bus_read(ADDR_DATA);
    check("blank_data_a", rd_a, 32'hF);
    check("blank_data_b_no_debounce", rd_b, 32'hF);
    tick(5);
    bus_read(ADDR_EDGECAP);
    check("blank_edgecap_a", rd_a, 32'h0);
    check("blank_edgecap_b", rd_b, 32'h0);

    // Debounce: 5-cycle pulse is rejected, 9-cycle hold is accepted
    in_b = 4'h0;
    tick(14);
    bus_read(ADDR_DATA);
    check("deb_settle_low", rd_b, 32'h0);
    in_b = 4'b0010;
    tick(5);
    in_b = 4'b0000;
    tick(15);
    bus_read(ADDR_DATA);
    check("deb_pulse_data", rd_b, 32'h0);
    bus_read(ADDR_EDGECAP);
    check("deb_pulse_edgecap", rd_b, 32'h0);
    in_b = 4'b0010;
    tick(9);
    in_b = 4'b0000;
    tick(2);
    bus_read(ADDR_DATA);
    check("deb_hold_data", rd_b, 32'h2);
    bus_read(ADDR_EDGECAP);
    check("deb_hold_edgecap", rd_b, 32'h2);
    check("deb_irq_masked", irq_b, 1'b0);

    // 32-bit, any-edge: bit31 both directions
    in_c[31] = 1'b1;
    tick(12);
    bus_read(ADDR_EDGECAP);
    check("w32_rise_edgecap", rd_c, 32'h80000000);
    bus_read(ADDR_DATA);
    check("w32_data", rd_c, 32'h80000000);
    bus_write(2, ADDR_EDGECAP, 32'h80000000);
    bus_read(ADDR_EDGECAP);
    check("w32_clear", rd_c, 32'h0);
    in_c = '0;
    tick(12);
    bus_read(ADDR_EDGECAP);
    check("w32_fall_edgecap", rd_c, 32'h80000000);
    bus_write(2, ADDR_IRQMASK, 32'hFFFFFFFF);
    check("w32_irq", irq_c, 1'b1);

    // Reset in the middle of a debounce window discards everything
    in_c = 32'h1;
    tick(4);
    check("w32_pre_rst_rd", rd_c, 32'hFFFFFFFF);
    reset_n = 1'b0;
    #1;
    check("w32_rst_rd", rd_c, 32'h0);
    check("w32_rst_irq", irq_c, 1'b0);
    in_c = '0;
    tick(2);
    reset_n = 1'b1;
    tick(8);
    bus_read(ADDR_DATA);
    check("w32_post_data", rd_c, 32'h0);
    bus_read(ADDR_IRQMASK);
    check("w32_post_irqmask", rd_c, 32'h0);
    bus_read(ADDR_EDGECAP);
    check("w32_post_edgecap", rd_c, 32'h0);
    check("w32_post_irq", irq_c, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nios_pio_capture.md
NIOS_PIO_CAPTURE -- requirements
Module: nios_pio_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the number of input bits (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of input synchronizer flops (2..4).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 0, the per-bit stability count (0 = bypass, max 65535).
REQ-004 SHALL have parameter EDGE_TYPE, default 0, the capture edge (0 rising, 1 falling, 2 any).
REQ-005 SHALL have port clk, input, 1 bit, the single clock for all logic.
REQ-006 SHALL have port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-007 SHALL have port address, input, 2 bits, the Avalon-MM word address.
REQ-008 SHALL have port chipselect, input, 1 bit, the slave select.
REQ-009 SHALL have port write_n, input, 1 bit, an active-low write strobe qualified by chipselect.
REQ-010 SHALL have port writedata, input, 32 bits, the write data.
REQ-011 SHALL have port in_port, input, WIDTH bits, the asynchronous external inputs.
REQ-012 SHALL have port readdata, output, 32 bits, the registered read data.
REQ-013 SHALL have port irq, output, 1 bit, the level interrupt request.

Function
REQ-014 SHALL pass each in_port bit through a SYNC_STAGES-deep flop chain before any other use.
REQ-015 SHALL, when DEBOUNCE_CYCLES>0, update bit i of the stable register only after the synchronized bit differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-016 SHALL clear the bit i debounce counter on any cycle the synchronized bit equals stable[i].
REQ-017 SHALL, when DEBOUNCE_CYCLES=0, make stable equal the synchronizer output.
REQ-018 SHALL keep prev, a one-cycle delayed copy of stable, and detect edges per bit by comparing stable with prev according to EDGE_TYPE.
REQ-019 SHALL implement the register map: addr 0 data (RO, stable); addr 1 reserved (reads 0, writes ignored); addr 2 irqmask (RW); addr 3 edgecapture (read; writing 1 to a bit clears it).
REQ-020 SHALL register readdata every cycle from the address decode, giving 1-cycle read latency, with no read strobe used.
REQ-021 SHALL return zero in readdata bits 31..WIDTH and ignore those bits of writedata.
REQ-022 SHALL set edgecapture[i] on a detected edge and hold it until it is cleared by write.
REQ-023 SHALL let a set win over a clear when an edge and a write-1-clear hit the same bit in the same cycle.
REQ-024 SHALL drive irq = OR(edgecapture & irqmask) combinationally from registers, with no other logic on that path.
REQ-025 SHALL take effect on irq in the cycle after an irqmask write, with no captured edge lost.
REQ-026 SHALL blank edge capture for SYNC_STAGES+1 cycles after reset release, loading stable directly from the synchronizer with no debounce during that time.
REQ-027 SHALL apply writes only when chipselect=1 and write_n=0.

Reset
REQ-028 SHALL asynchronously clear the synchronizer flops, stable, prev, debounce counters, irqmask, edgecapture, readdata and the blanking counter when reset_n=0.
REQ-029 SHALL hold irq=0 and readdata=0 during reset.
REQ-030 SHALL, on reset assertion mid-debounce or mid-capture, discard all pending state, with no capture occurring on reset release.

Structure
REQ-031 SHALL place the register address constants (ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3) and the EDGE_TYPE encodings in the shared package nios_pio_pkg.
REQ-032 SHALL implement one sub-module, nios_pio_debounce, which is per-bit, parameterised by SYNC_STAGES and DEBOUNCE_CYCLES, and instantiated WIDTH times via generate.
REQ-033 SHALL contain no latches and no clocks other than clk.

Verification
REQ-034 SHALL cover: WIDTH=4, in_port=4'b1010 held 10 cycles, read addr 0 -> readdata=32'h0000000A one cycle after address is presented.
REQ-035 SHALL cover: EDGE_TYPE=0, in_port bit0 rises, irqmask=1 -> edgecapture=1 and irq=1 within SYNC_STAGES+2 cycles; write 1 to addr 3 -> irq=0 the next cycle.
REQ-036 SHALL cover: DEBOUNCE_CYCLES=8, bit1 pulses high for 5 cycles -> stable unchanged and no capture; bit1 held high for 9 cycles -> stable[1]=1 and edgecapture[1]=1.
REQ-037 SHALL cover: edge on bit2 in the same cycle as a write of 32'h4 to addr 3 -> edgecapture[2] remains 1.
REQ-038 SHALL cover: in_port=4'hF during reset release -> no edgecapture bits set and data reads 4'hF after blanking ends.
REQ-039 SHALL cover: WIDTH=32, EDGE_TYPE=2, toggle bit31 -> edgecapture=32'h80000000; reset_n pulsed low mid-debounce -> all registers return to 0.
